// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock / flush controller for the 5-stage RV32I core.
//
// Tracks destination-register info for the instructions in EX, MEM and WB and
// uses it to stall, flush and select operand bypasses for the DEC instruction.
// Also sequences the multi-cycle redirect bubble after a taken branch/jump.
//
// Build option:
//   HZD_FORWARD_EN  defined   -> operand forwarding active; only load-use stalls.
//                   undefined -> no forwarding; any RAW stalls until the producer
//                                has left WB; fwd_*_sel and dec_byp_* read 0.
//
// Parameters:
//   REDIRECT_BUBBLES  cycles dec_flush stays high per redirect (1..7)
//   RA_W              register address width
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   dec_valid                DEC holds a real instruction
//   dec_rs1/dec_rs2          DEC source registers
//   dec_use_rs1/dec_use_rs2  DEC reads that source
//   dec_rd, dec_rf_wb        DEC destination and write-enable
//   dec_load                 DEC is a load
//   ex_redirect              taken branch/jump resolved in EX
//   mem_stall                data memory not ready; freeze everything
//   if_stall                 hold PC and IF/DEC
//   if_flush                 squash IF/DEC
//   dec_flush                load a bubble into DEC/EX
//   dec_byp_a/dec_byp_b      DEC operand takes wb_data
//   fwd_a_sel/fwd_b_sel      EX operand source: 00 regfile, 01 MEM, 10 WB
module hazard_ctrl #(
    parameter int unsigned REDIRECT_BUBBLES = 2,
    parameter int unsigned RA_W             = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    input  logic [RA_W-1:0] dec_rs1,
    input  logic [RA_W-1:0] dec_rs2,
    input  logic            dec_use_rs1,
    input  logic            dec_use_rs2,
    input  logic [RA_W-1:0] dec_rd,
    input  logic            dec_rf_wb,
    input  logic            dec_load,
    input  logic            ex_redirect,
    input  logic            mem_stall,
    output logic            if_stall,
    output logic            if_flush,
    output logic            dec_flush,
    output logic            dec_byp_a,
    output logic            dec_byp_b,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel
);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
    } shadow_t;

    typedef enum logic {RUN, REDIR} state_t;

    localparam logic [2:0] CNT_LOAD = 3'(REDIRECT_BUBBLES - 1);

    shadow_t    ex_s, mem_s, wb_s;
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;

    logic redir_in, flushing, hz, load_use;
    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;

    function automatic logic match(input shadow_t s, input logic [RA_W-1:0] r,
                                   input logic use_r);
        return use_r & s.v & s.we & (s.rd == r) & (r != '0);
    endfunction

    always_comb begin
        // Masked by rst so every output reads 0 while reset is held.
        redir_in = ex_redirect & ~rst;

        ex_a  = match(ex_s,  dec_rs1, dec_use_rs1);
        ex_b  = match(ex_s,  dec_rs2, dec_use_rs2);
        mem_a = match(mem_s, dec_rs1, dec_use_rs1);
        mem_b = match(mem_s, dec_rs2, dec_use_rs2);
        wb_a  = match(wb_s,  dec_rs1, dec_use_rs1);
        wb_b  = match(wb_s,  dec_rs2, dec_use_rs2);

        load_use = (ex_a | ex_b) & ex_s.ld;
`ifdef HZD_FORWARD_EN
        hz = load_use;
`else
        hz = load_use | ex_a | ex_b | mem_a | mem_b | wb_a | wb_b;
`endif

        flushing  = (redir_in | (state == REDIR)) & ~mem_stall;
        if_flush  = redir_in & ~mem_stall;
        dec_flush = ~mem_stall & (flushing | hz);
        // A redirect kills the DEC instruction, so its hazard must not stall.
        if_stall  = mem_stall | (hz & ~flushing);

        state_n = state;
        cnt_n   = cnt;
        if (!mem_stall) begin
            if (redir_in) begin
                cnt_n   = CNT_LOAD;
                state_n = (CNT_LOAD != 3'd0) ? REDIR : RUN;
            end else if (state == REDIR) begin
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_n = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_s  <= '0;
            mem_s <= '0;
            wb_s  <= '0;
            state <= RUN;
            cnt   <= '0;
        end else if (!mem_stall) begin
            wb_s  <= mem_s;
            mem_s <= ex_s;
            if (dec_valid && !dec_flush)
                ex_s <= '{v: 1'b1, rd: dec_rd, we: dec_rf_wb, ld: dec_load};
            else
                ex_s <= '0;
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

`ifdef HZD_FORWARD_EN
    logic [1:0] fwd_a_n, fwd_b_n;
    logic [1:0] fwd_a_q, fwd_b_q;

    always_comb begin
        // EX (MEM result next cycle) is newer than MEM, so it wins.
        fwd_a_n = ex_a ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
        fwd_b_n = ex_b ? 2'b01 : (mem_b ? 2'b10 : 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else if (!mem_stall) begin
            if (dec_valid && !dec_flush) begin
                fwd_a_q <= fwd_a_n;
                fwd_b_q <= fwd_b_n;
            end else begin
                fwd_a_q <= '0;
                fwd_b_q <= '0;
            end
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
    // RegFile has no write-through, so DEC must take the WB value directly.
    assign dec_byp_a = wb_a & dec_valid;
    assign dec_byp_b = wb_b & dec_valid;
`else
    assign fwd_a_sel = '0;
    assign fwd_b_sel = '0;
    assign dec_byp_a = 1'b0;
    assign dec_byp_b = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HZD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_use_rs1, dec_use_rs2, dec_rf_wb, dec_load;
    logic       ex_redirect, mem_stall;
    logic       if_stall, if_flush, dec_flush, dec_byp_a, dec_byp_b;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int total = 0;
    int bad   = 0;

    // Expected-vector layout: {if_stall, if_flush, dec_flush, byp_a, byp_b, fwd_a[1:0], fwd_b[1:0]}
    localparam logic [8:0] Z     = 9'b000_00_00_00;
    localparam logic [8:0] STALL = 9'b101_00_00_00;
    localparam logic [8:0] REDIR = 9'b011_00_00_00;
    localparam logic [8:0] BUBB  = 9'b001_00_00_00;
    localparam logic [8:0] MSTL  = 9'b100_00_00_00;

    hazard_ctrl #(.REDIRECT_BUBBLES(2), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_rf_wb(dec_rf_wb), .dec_load(dec_load),
        .ex_redirect(ex_redirect), .mem_stall(mem_stall),
        .if_stall(if_stall), .if_flush(if_flush), .dec_flush(dec_flush),
        .dec_byp_a(dec_byp_a), .dec_byp_b(dec_byp_b),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [8:0] exp);
        #1;
        check(tag, {if_stall, if_flush, dec_flush, dec_byp_a, dec_byp_b,
                    fwd_a_sel, fwd_b_sel}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic u1, input logic u2, input logic [4:0] rd,
                           input logic wb, input logic ld);
        dec_valid = v; dec_rs1 = r1; dec_rs2 = r2;
        dec_use_rs1 = u1; dec_use_rs2 = u2;
        dec_rd = rd; dec_rf_wb = wb; dec_load = ld;
    endtask

    task automatic nop();
        set_dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        mem_stall   = 1'b0;
        ex_redirect = 1'b1;
        repeat (2) tick();
        expect_out("reset_outputs", Z);
        ex_redirect = 1'b0;
        rst = 1'b0;
        tick();
        expect_out("idle_after_reset", Z);

        // 1) add x5 ; add x6,x5,x7
        set_dec(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        expect_out("alu_prod_issue", Z);
        tick();
        set_dec(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        expect_out("alu_raw_c0", FWD ? Z : STALL);
        tick();
        expect_out("alu_raw_c1", FWD ? 9'b000_00_01_00 : STALL);
        tick();
        expect_out("alu_raw_c2", FWD ? 9'b000_10_10_00 : STALL);
        tick();
        expect_out("alu_raw_c3", Z);
        drain();

        // 2) lw x5 ; add x6,x5,x0
        set_dec(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        expect_out("lw_issue", Z);
        tick();
        set_dec(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        expect_out("ldu_c0", STALL);
        tick();
        expect_out("ldu_c1", FWD ? Z : STALL);
        tick();
        expect_out("ldu_c2", FWD ? 9'b000_10_10_00 : STALL);
        tick();
        expect_out("ldu_c3", Z);
        drain();

        // 3) redirect pulse: if_flush 1 cycle, dec_flush 2 cycles
        ex_redirect = 1'b1;
        expect_out("redir_c0", REDIR);
        tick();
        ex_redirect = 1'b0;
        expect_out("redir_c1", BUBB);
        tick();
        expect_out("redir_c2", Z);

        // redirect under mem_stall is ignored
        ex_redirect = 1'b1;
        mem_stall   = 1'b1;
        expect_out("redir_memstall", MSTL);
        tick();
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;
        expect_out("redir_ignored", Z);
        tick();

        // second redirect while in REDIR reloads the counter
        ex_redirect = 1'b1;
        expect_out("reload_c0", REDIR);
        tick();
        expect_out("reload_c1", REDIR);
        tick();
        ex_redirect = 1'b0;
        expect_out("reload_c2", BUBB);
        tick();
        expect_out("reload_c3", Z);
        drain();

        // 4) redirect coincides with load-use hazard
        set_dec(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_dec(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        expect_out("redir_hz_c0", REDIR);
        tick();
        ex_redirect = 1'b0;
        nop();
        expect_out("redir_hz_c1", BUBB);
        tick();
        expect_out("redir_hz_c2", Z);
        drain();

        // 5) mem_stall for 3 cycles during a load-use
        set_dec(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_dec(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("mstall_hold%0d", i), MSTL);
            tick();
        end
        mem_stall = 1'b0;
        expect_out("mstall_ldu_c0", STALL);
        tick();
        expect_out("mstall_ldu_c1", FWD ? Z : STALL);
        tick();
        expect_out("mstall_ldu_c2", FWD ? 9'b000_10_10_00 : STALL);
        tick();
        expect_out("mstall_ldu_c3", Z);
        drain();

        // 6) reset while REDIR with cnt=1
        ex_redirect = 1'b1;
        expect_out("rst_redir_c0", REDIR);
        tick();
        ex_redirect = 1'b0;
        rst = 1'b1;
        expect_out("rst_in_redir", Z);
        tick();
        rst = 1'b0;
        expect_out("rst_no_carry", Z);
        tick();

        // x0 destinations never hazard: lw x0 ; add x6,x0,x0
        set_dec(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_dec(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        expect_out("x0_no_hz_c0", Z);
        tick();
        expect_out("x0_no_hz_c1", Z);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
